// File: rtl/cache_fill_ctrl.sv
// Miss-handling controller: arbitrates I/D cache misses (D first), streams an 8-word
// block from pipelined main memory into the LRU victim way, then commits tag/valid and LRU.
module cache_fill_ctrl #(
  parameter int MEM_LAT = 4,
  parameter int WORDS   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmiss,
  input  logic [15:0] dmiss_addr,
  input  logic        imiss,
  input  logic [15:0] imiss_addr,
  input  logic        victim_way0,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  input  logic        mem_data_valid,
  output logic [63:0] set_en,
  output logic        fill_target,
  output logic        fill_way,
  output logic        fill_word_we,
  output logic [2:0]  fill_word_sel,
  output logic        tag_we,
  output logic [5:0]  fill_tag,
  output logic        lru_we,
  output logic        lru_block,
  output logic        ifill_done,
  output logic        dfill_done,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic [3:0] LAST = 4'(WORDS);

  state_t      state;
  logic [15:4] blk_q;
  logic [3:0]  tx;
  logic [3:0]  rx;
  logic        word_take;
  logic        unused_offset;

  // The byte offset of a miss never matters: fills always cover the whole block.
  assign unused_offset = ^{dmiss_addr[3:0], imiss_addr[3:0]};

  assign word_take = (state == FILL) && mem_data_valid && (rx < LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      blk_q       <= '0;
      tx          <= '0;
      rx          <= '0;
      fill_target <= 1'b0;
      fill_way    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dmiss) begin
            blk_q       <= dmiss_addr[15:4];
            fill_target <= 1'b1;
            state       <= LOOKUP;
          end else if (imiss) begin
            blk_q       <= imiss_addr[15:4];
            fill_target <= 1'b0;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          // The LRU array answers for the set driven this cycle; fill the LRU way.
          fill_way <= ~victim_way0;
          state    <= FILL;
        end
        FILL: begin
          if (tx < LAST) tx <= tx + 4'd1;
          if (word_take) begin
            rx <= rx + 4'd1;
            if (rx == LAST - 4'd1) state <= COMMIT;
          end
        end
        COMMIT: begin
          tx    <= '0;
          rx    <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Everything below decodes registered state; only the word write follows mem_data_valid.
  assign mem_en        = (state == FILL) && (tx < LAST);
  assign mem_addr      = mem_en ? {blk_q, tx[2:0], 1'b0} : 16'h0000;
  assign set_en        = (state != IDLE) ? (64'd1 << blk_q[9:4]) : 64'd0;
  assign fill_tag      = blk_q[15:10];
  assign fill_word_we  = word_take;
  assign fill_word_sel = rx[2:0];
  assign tag_we        = (state == COMMIT);
  assign lru_we        = (state == COMMIT);
  assign lru_block     = (state == COMMIT) && !fill_way;
  assign dfill_done    = (state == COMMIT) && fill_target;
  assign ifill_done    = (state == COMMIT) && !fill_target;
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

  // Ideal memory never has more than MEM_LAT reads in flight.
  assert property (@(posedge clk) disable iff (!rst_n)
    (state == FILL) |-> (({1'b0, tx} - {1'b0, rx}) <= 5'(MEM_LAT)));

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: per-cycle vector table for a single D miss,
// plus hand-written sequences for arbitration, victim way 1, mid-fill reset and miss drop.
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmiss, imiss, victim_way0, mem_data_valid;
  logic [15:0] dmiss_addr, imiss_addr;
  logic        mem_en, fill_target, fill_way, fill_word_we, tag_we, lru_we, lru_block;
  logic        ifill_done, dfill_done, busy;
  logic [15:0] mem_addr;
  logic [63:0] set_en;
  logic [2:0]  fill_word_sel;
  logic [5:0]  fill_tag;
  logic [1:0]  state_dbg;

  cache_fill_ctrl #(.MEM_LAT(4), .WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .dmiss(dmiss), .dmiss_addr(dmiss_addr), .imiss(imiss), .imiss_addr(imiss_addr),
    .victim_way0(victim_way0), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_data_valid(mem_data_valid), .set_en(set_en), .fill_target(fill_target),
    .fill_way(fill_way), .fill_word_we(fill_word_we), .fill_word_sel(fill_word_sel),
    .tag_we(tag_we), .fill_tag(fill_tag), .lru_we(lru_we), .lru_block(lru_block),
    .ifill_done(ifill_done), .dfill_done(dfill_done), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc;
  logic [3:0] hist;
  logic       mdv_force;

  logic [1:0]  st_a   [64];
  logic [15:0] addr_a [64];
  logic [2:0]  sel_a  [64];
  logic [63:0] set_a  [64];
  logic [5:0]  tag_a  [64];
  logic [63:0] men_v, we_v, tagwe_v, lruwe_v, lrub_v, dd_v, id_v, way_v, tgt_v, busy_v;

  typedef struct {
    logic        dmiss;
    logic        mdv;
    logic [1:0]  st;
    logic        men;
    logic [15:0] addr;
    logic        we;
    logic [2:0]  sel;
    logic        commit;
    logic [63:0] set_en;
    logic        hold;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int first_hi(input logic [63:0] v);
    for (int i = 0; i < 64; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Called at a falling edge: memory model drives this cycle, outputs are captured, then advance.
  task automatic cycle();
    mem_data_valid = hist[3] | mdv_force;
    #1;
    if (cyc < 64) begin
      st_a[cyc] = state_dbg;  addr_a[cyc] = mem_addr; sel_a[cyc] = fill_word_sel;
      set_a[cyc] = set_en;    tag_a[cyc] = fill_tag;
      men_v[cyc] = mem_en;    we_v[cyc] = fill_word_we; tagwe_v[cyc] = tag_we;
      lruwe_v[cyc] = lru_we;  lrub_v[cyc] = lru_block;  dd_v[cyc] = dfill_done;
      id_v[cyc] = ifill_done; way_v[cyc] = fill_way;    tgt_v[cyc] = fill_target;
      busy_v[cyc] = busy;
    end
    hist = {hist[2:0], mem_en};
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_capture();
    cyc = 0;
    men_v = '0; we_v = '0; tagwe_v = '0; lruwe_v = '0; lrub_v = '0;
    dd_v = '0; id_v = '0; way_v = '0; tgt_v = '0; busy_v = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    dmiss = 1'b0; imiss = 1'b0; dmiss_addr = '0; imiss_addr = '0;
    victim_way0 = 1'b1; mdv_force = 1'b0; mem_data_valid = 1'b0; hist = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_capture();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    dmiss = 1'b0; imiss = 1'b0; dmiss_addr = '0; imiss_addr = '0;
    victim_way0 = 1'b1; mdv_force = 1'b0; mem_data_valid = 1'b0; hist = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset state", state_dbg, 2'd0);
    chk("reset mem_en", mem_en, 1'b0);
    chk("reset set_en", set_en, 64'd0);
    chk("reset busy", busy, 1'b0);
    chk("reset mem_addr", mem_addr, 16'h0);
    chk("reset fill_way", fill_way, 1'b0);
    chk("reset fill_target", fill_target, 1'b0);

    // Vector table: D miss at 0x1234, victim way 0, spurious valids in idle/lookup/commit
    for (int c = 0; c < 17; c++) begin
      tbl[c].dmiss  = (c <= 14);
      tbl[c].mdv    = (c <= 1) || (c >= 14);
      tbl[c].st     = (c == 0) ? 2'd0 : (c == 1) ? 2'd1 : (c <= 13) ? 2'd2 : (c == 14) ? 2'd3 : 2'd0;
      tbl[c].men    = (c >= 2) && (c <= 9);
      tbl[c].addr   = 16'h1230 + 16'(2 * (c - 2));
      tbl[c].we     = (c >= 6) && (c <= 13);
      tbl[c].sel    = 3'(c - 6);
      tbl[c].commit = (c == 14);
      tbl[c].set_en = ((c >= 1) && (c <= 14)) ? (64'd1 << 35) : 64'd0;
      tbl[c].hold   = (c >= 1) && (c <= 14);
    end
    do_reset();
    dmiss_addr = 16'h1234;
    for (int i = 0; i < 17; i++) begin
      dmiss = tbl[i].dmiss;
      mdv_force = tbl[i].mdv;
      cycle();
      chk($sformatf("t c%0d state", i), st_a[i], tbl[i].st);
      chk($sformatf("t c%0d busy", i), busy_v[i], tbl[i].st != 2'd0);
      chk($sformatf("t c%0d mem_en", i), men_v[i], tbl[i].men);
      if (tbl[i].men) chk($sformatf("t c%0d mem_addr", i), addr_a[i], tbl[i].addr);
      chk($sformatf("t c%0d word_we", i), we_v[i], tbl[i].we);
      if (tbl[i].we) chk($sformatf("t c%0d word_sel", i), sel_a[i], tbl[i].sel);
      chk($sformatf("t c%0d set_en", i), set_a[i], tbl[i].set_en);
      chk($sformatf("t c%0d tag_we", i), tagwe_v[i], tbl[i].commit);
      chk($sformatf("t c%0d lru_we", i), lruwe_v[i], tbl[i].commit);
      chk($sformatf("t c%0d lru_block", i), lrub_v[i], tbl[i].commit);
      chk($sformatf("t c%0d dfill_done", i), dd_v[i], tbl[i].commit);
      chk($sformatf("t c%0d ifill_done", i), id_v[i], 1'b0);
      if (tbl[i].hold) begin
        chk($sformatf("t c%0d fill_tag", i), tag_a[i], 6'h04);
        chk($sformatf("t c%0d fill_target", i), tgt_v[i], 1'b1);
        chk($sformatf("t c%0d fill_way", i), way_v[i], 1'b0);
      end
    end
    mdv_force = 1'b0;

    // Simultaneous D and I misses: D first, one idle cycle, then I
    do_reset();
    dmiss = 1'b1; dmiss_addr = 16'h2040;
    imiss = 1'b1; imiss_addr = 16'h0100;
    for (int c = 0; c < 35; c++) begin
      if (c > 0 && dd_v[c-1]) dmiss = 1'b0;
      if (c > 0 && id_v[c-1]) imiss = 1'b0;
      cycle();
    end
    chk("arb dfill_done cycle", first_hi(dd_v), 14);
    chk("arb ifill_done cycle", first_hi(id_v), 29);
    chk("arb dfill_done count", $countones(dd_v), 1);
    chk("arb ifill_done count", $countones(id_v), 1);
    chk("arb target first", tgt_v[1], 1'b1);
    chk("arb set first", set_a[1], 64'd1 << 4);
    chk("arb d base addr", addr_a[2], 16'h2040);
    chk("arb idle gap", st_a[15], 2'd0);
    chk("arb i lookup", st_a[16], 2'd1);
    chk("arb target second", tgt_v[16], 1'b0);
    chk("arb set second", set_a[16], 64'd1 << 16);
    chk("arb i base addr", addr_a[17], 16'h0100);

    // I miss at 0xFFF8 with way 1 as victim; victim_way0 only valid during lookup
    do_reset();
    imiss = 1'b1; imiss_addr = 16'hFFF8;
    for (int c = 0; c < 17; c++) begin
      if (c > 0 && id_v[c-1]) imiss = 1'b0;
      victim_way0 = (c == 1) ? 1'b0 : 1'b1;
      cycle();
    end
    chk("way1 set_en", set_a[1], 64'd1 << 63);
    chk("way1 fill_way early", way_v[2], 1'b1);
    chk("way1 fill_way commit", way_v[14], 1'b1);
    chk("way1 first addr", addr_a[2], 16'hFFF0);
    chk("way1 last addr", addr_a[9], 16'hFFFE);
    chk("way1 ifill_done cycle", first_hi(id_v), 14);
    chk("way1 tag_we cycle", first_hi(tagwe_v), 14);
    chk("way1 lru_block", lrub_v[14], 1'b0);
    chk("way1 tag", tag_a[14], 6'h3F);
    chk("way1 target", tgt_v[14], 1'b0);
    chk("way1 no dfill_done", $countones(dd_v), 0);
    victim_way0 = 1'b1;

    // Reset asserted mid-fill, miss still held: restart from lookup
    do_reset();
    dmiss = 1'b1; dmiss_addr = 16'h1234;
    for (int c = 0; c < 8; c++) cycle();
    rst_n = 1'b0;
    mem_data_valid = 1'b0;
    #1;
    chk("rst mid state", state_dbg, 2'd0);
    chk("rst mid mem_en", mem_en, 1'b0);
    chk("rst mid mem_addr", mem_addr, 16'h0);
    chk("rst mid set_en", set_en, 64'd0);
    chk("rst mid busy", busy, 1'b0);
    chk("rst mid word_we", fill_word_we, 1'b0);
    chk("rst mid tag_we", tag_we, 1'b0);
    chk("rst mid lru_we", lru_we, 1'b0);
    chk("rst mid dfill_done", dfill_done, 1'b0);
    chk("rst mid fill_tag", fill_tag, 6'h00);
    chk("rst mid fill_target", fill_target, 1'b0);
    chk("rst mid fill_way", fill_way, 1'b0);
    @(negedge clk);
    @(negedge clk);
    hist = '0;
    rst_n = 1'b1;
    clear_capture();
    for (int c = 0; c < 17; c++) begin
      if (c > 0 && dd_v[c-1]) dmiss = 1'b0;
      cycle();
    end
    chk("restart idle", st_a[0], 2'd0);
    chk("restart lookup", st_a[1], 2'd1);
    chk("restart first addr", addr_a[2], 16'h1230);
    chk("restart first word", {we_v[6], sel_a[6]}, 4'b1_000);
    chk("restart last word", {we_v[13], sel_a[13]}, 4'b1_111);
    chk("restart word count", $countones(we_v), 8);
    chk("restart dfill_done cycle", first_hi(dd_v), 14);

    // Miss dropped mid-fill still completes exactly once
    do_reset();
    dmiss_addr = 16'h0A56;
    for (int c = 0; c < 18; c++) begin
      dmiss = (c < 5);
      cycle();
    end
    chk("drop dfill_done cycle", first_hi(dd_v), 14);
    chk("drop dfill_done count", $countones(dd_v), 1);
    chk("drop tag_we count", $countones(tagwe_v), 1);
    chk("drop word count", $countones(we_v), 8);
    chk("drop idle c15", st_a[15], 2'd0);
    chk("drop idle c17", st_a[17], 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
